// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, the data/instruction caches and main memory.
// The slave view belongs to the arbiter; the master view is the surrounding system.
interface mem_arbiter_if;
    logic        D_READ;
    logic        D_WRITE;
    logic [5:0]  D_ADDRESS;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;

    logic        I_READ;
    logic [5:0]  I_ADDRESS;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;

    logic        M_READ;
    logic        M_WRITE;
    logic [5:0]  M_ADDRESS;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_BUSYWAIT;

    modport slave (
        input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA, I_READ, I_ADDRESS,
        input  M_READDATA, M_BUSYWAIT,
        output D_READDATA, D_BUSYWAIT, I_READDATA, I_BUSYWAIT,
        output M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
    );

    modport master (
        output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA, I_READ, I_ADDRESS,
        output M_READDATA, M_BUSYWAIT,
        input  D_READDATA, D_BUSYWAIT, I_READDATA, I_BUSYWAIT,
        input  M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the data and
// instruction caches, one transaction at a time with a one-cycle bubble after each.
module mem_arbiter (
    input  logic          CLK,
    input  logic          RESET,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I, RELEASE} state_t;

    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        seen_busy_q, seen_busy_d;
    logic        m_read_q, m_read_d;
    logic        m_write_q, m_write_d;
    logic [5:0]  m_address_q, m_address_d;
    logic [31:0] m_writedata_q, m_writedata_d;
    logic [31:0] d_readdata_q, d_readdata_d;
    logic [31:0] i_readdata_q, i_readdata_d;

    logic d_req, i_req, grant_d, grant_i, serving, done;

    assign d_req   = bus.D_READ | bus.D_WRITE;
    assign i_req   = bus.I_READ;
    assign serving = (state_q == SERVE_D) || (state_q == SERVE_I);
    // Memory must have been seen busy first, so the idle level before it reacts is not mistaken for completion.
    assign done    = serving && seen_busy_q && !bus.M_BUSYWAIT;
    assign grant_d = (state_q == IDLE) && d_req && (!i_req || (last_grant_q == OWN_I));
    assign grant_i = (state_q == IDLE) && i_req && !grant_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            owner_q       <= OWN_D;
            last_grant_q  <= OWN_I;
            seen_busy_q   <= 1'b0;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            d_readdata_q  <= '0;
            i_readdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            seen_busy_q   <= seen_busy_d;
            m_read_q      <= m_read_d;
            m_write_q     <= m_write_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            d_readdata_q  <= d_readdata_d;
            i_readdata_q  <= i_readdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = SERVE_D;
                    owner_d      = OWN_D;
                    last_grant_d = OWN_D;
                end else if (grant_i) begin
                    state_d      = SERVE_I;
                    owner_d      = OWN_I;
                    last_grant_d = OWN_I;
                end
            end
            SERVE_D, SERVE_I: begin
                if (done) state_d = RELEASE;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seen_busy_d   = seen_busy_q;
        m_read_d      = m_read_q;
        m_write_d     = m_write_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        d_readdata_d  = d_readdata_q;
        i_readdata_d  = i_readdata_q;
        if (grant_d) begin
            // Read wins when both data strobes are high.
            m_read_d      = bus.D_READ;
            m_write_d     = bus.D_WRITE & ~bus.D_READ;
            m_address_d   = bus.D_ADDRESS;
            m_writedata_d = bus.D_WRITEDATA;
            seen_busy_d   = 1'b0;
        end else if (grant_i) begin
            m_read_d      = 1'b1;
            m_write_d     = 1'b0;
            m_address_d   = bus.I_ADDRESS;
            m_writedata_d = '0;
            seen_busy_d   = 1'b0;
        end else if (done) begin
            m_read_d  = 1'b0;
            m_write_d = 1'b0;
            if (m_read_q) begin
                if (state_q == SERVE_D) d_readdata_d = bus.M_READDATA;
                else                    i_readdata_d = bus.M_READDATA;
            end
        end else if (serving && bus.M_BUSYWAIT) begin
            seen_busy_d = 1'b1;
        end
    end

    assign bus.M_READ      = m_read_q;
    assign bus.M_WRITE     = m_write_q;
    assign bus.M_ADDRESS   = m_address_q;
    assign bus.M_WRITEDATA = m_writedata_q;
    assign bus.D_READDATA  = d_readdata_q;
    assign bus.I_READDATA  = i_readdata_q;
    assign bus.D_BUSYWAIT  = !RESET && d_req && !((state_q == RELEASE) && (owner_q == OWN_D));
    assign bus.I_BUSYWAIT  = !RESET && i_req && !((state_q == RELEASE) && (owner_q == OWN_I));
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, CLK; RESET is synchronous and active-high, sampled only on the CLK rising edge.
REQ-002 CLK  in  1  system clock; all state changes on its rising edge.
REQ-003 RESET  in  1  synchronous active-high reset.
REQ-004 D_READ, D_WRITE  in  1 each  data-cache request strobes, held until its D_BUSYWAIT falls.
REQ-005 D_ADDRESS  in  6  data-side block address.
REQ-006 D_WRITEDATA  in  32  data-side write block.
REQ-007 D_READDATA  out  32  registered data-side read block.
REQ-008 D_BUSYWAIT  out  1  data-side stall.
REQ-009 I_READ  in  1  instruction-cache read strobe, held until its I_BUSYWAIT falls.
REQ-010 I_ADDRESS  in  6  instruction-side block address.
REQ-011 I_READDATA  out  32  registered instruction-side read block.
REQ-012 I_BUSYWAIT  out  1  instruction-side stall.
REQ-013 M_READ, M_WRITE  out  1 each  main-memory strobes, registered.
REQ-014 M_ADDRESS  out  6; M_WRITEDATA  out  32  registered memory request fields.
REQ-015 M_READDATA  in  32; M_BUSYWAIT  in  1  memory response; memory raises M_BUSYWAIT the edge after a strobe and drops it when its data is valid.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SERVE_D, SERVE_I, RELEASE; an owner bit and a last_grant bit (D or I) are held alongside.
REQ-017 In IDLE, a pending request SHALL be granted at the next edge: the FSM enters SERVE_D or SERVE_I and latches address, write data and operation into internal registers.
REQ-018 When D and I both request in IDLE, the requester not equal to last_grant SHALL win (round-robin); last_grant is updated on every grant.
REQ-019 D_READ and D_WRITE both high SHALL be treated as a read; D_WRITE is ignored for that transaction.
REQ-020 In SERVE_x, M_READ/M_WRITE, M_ADDRESS and M_WRITEDATA SHALL be driven from the latched registers, independent of the live requester inputs.
REQ-021 A seen_busy flag SHALL be cleared on entry to SERVE_x and set on any edge in SERVE_x where M_BUSYWAIT=1.
REQ-022 Completion SHALL occur on the first edge in SERVE_x with seen_busy=1 and M_BUSYWAIT=0. At that edge:
- read: M_READDATA is captured into x_READDATA;
- M_READ and M_WRITE are cleared;
- the FSM enters RELEASE.
REQ-023 RELEASE SHALL last exactly one cycle, then go to IDLE; no grant is issued from RELEASE (one-cycle bubble between transactions).
REQ-024 x_BUSYWAIT SHALL be combinational, equal to (x request asserted) AND NOT (state==RELEASE AND owner==x), and forced 0 while RESET=1.
REQ-025 Minimum latency SHALL be 4 cycles from request to BUSYWAIT low: grant, memory busy, completion, RELEASE.
REQ-026 A request dropped before grant SHALL be removed from arbitration with no memory access.
REQ-027 A request dropped during SERVE_x SHALL still complete normally; read data is still captured.
REQ-028 x_READDATA SHALL hold its value until that requester's next read completion; writes never change D_READDATA.
REQ-029 A requester that keeps its strobe high through RELEASE SHALL be treated as a new request in IDLE (back-to-back access), subject to round-robin.

Reset
REQ-030 On a RESET edge the block SHALL enter IDLE, from any state including mid-SERVE, with:
- M_READ=M_WRITE=0, M_ADDRESS=0, M_WRITEDATA=0;
- D_READDATA=I_READDATA=0;
- seen_busy=0, owner=D, last_grant=I, so D wins the first tie.
REQ-031 A memory transaction aborted by RESET SHALL NOT update any x_READDATA, and the requester SHALL re-issue it.

Verification
REQ-032 D_READ addr 6'h05, memory returns 32'hDEADBEEF after 3 busy cycles -> M_READ rises 1 edge after request; D_BUSYWAIT low exactly one cycle with D_READDATA=32'hDEADBEEF.
REQ-033 D_READ and I_READ raised together after reset -> D served first, then I granted in the cycle after RELEASE; the second tie goes to I.
REQ-034 D_WRITE addr 6'h3F data 32'h12345678 -> M_WRITE=1, M_ADDRESS=6'h3F, M_WRITEDATA=32'h12345678 held stable through busy; I_READDATA and D_READDATA unchanged.
REQ-035 I_READ granted, RESET pulsed for one edge while M_BUSYWAIT=1 -> next cycle IDLE, M_READ=0, I_READDATA=0, I_BUSYWAIT high again once RESET falls with I_READ still held.
REQ-036 D_READ and D_WRITE both high, addr 6'h0A -> only M_READ asserted; completion captures data; D_READ dropped before grant in a separate run -> no M_READ pulse.
